// File: rtl/somador_bcd_3dig.sv
// Three-digit BCD adder: A + B + C_in converted to packed BCD by combinational double-dabble.
// Latency one cycle, one result per cycle, no handshake or backpressure.
module somador_bcd_3dig (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic        C_in,
  output logic [11:0] S,
  output logic        C_out
);

  logic [8:0]  w_sum;
  logic [11:0] w_bcd;
  logic [11:0] r_s;
  logic        r_c_out;

  assign w_sum = {1'b0, A} + {1'b0, B} + {8'd0, C_in};

  // Add-3 before each shift; nine shifts of a 9-bit value keep the hundreds digit at most 5
  always_comb begin
    w_bcd = 12'd0;
    for (int i = 8; i >= 0; i--) begin
      if (w_bcd[3:0] >= 4'd5)  w_bcd[3:0]  = w_bcd[3:0]  + 4'd3;
      if (w_bcd[7:4] >= 4'd5)  w_bcd[7:4]  = w_bcd[7:4]  + 4'd3;
      if (w_bcd[11:8] >= 4'd5) w_bcd[11:8] = w_bcd[11:8] + 4'd3;
      w_bcd = {w_bcd[10:0], w_sum[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= 12'h000;
      r_c_out <= 1'b0;
    end else begin
      r_s     <= w_bcd;
      r_c_out <= w_sum[8];
    end
  end

  assign S     = r_s;
  assign C_out = r_c_out;

endmodule

// File: tb/tb_somador_bcd_3dig.sv
// Self-checking bench for somador_bcd_3dig: directed table, sequences, reset cases and sweeps.
module tb_somador_bcd_3dig;

  logic        clk;
  logic        rst_n;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        C_in;
  logic [11:0] S;
  logic        C_out;

  int checks;
  int failures;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic [11:0] s;
    logic        c;
  } vec_t;

  vec_t vecs[15];

  somador_bcd_3dig dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .S     (S),
    .C_out (C_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] exp_s, input logic exp_c);
    checks++;
    if (S !== exp_s || C_out !== exp_c || S[3:0] > 4'd9 || S[7:4] > 4'd9 || S[11:8] > 4'd9) begin
      failures++;
      $display("FAIL %s: got S=%h C_out=%b, expected S=%h C_out=%b", name, S, C_out, exp_s, exp_c);
    end
  endtask

  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    A = a;
    B = b;
    C_in = cin;
  endtask

  task automatic apply_check(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic cin, input logic [11:0] exp_s, input logic exp_c);
    apply(a, b, cin);
    @(posedge clk);
    #1;
    check(name, exp_s, exp_c);
  endtask

  function automatic logic [12:0] model(input int a, input int b, input int cin);
    int t;
    logic [3:0] h, te, u;
    t  = a + b + cin;
    h  = 4'(t / 100);
    te = 4'((t / 10) % 10);
    u  = 4'(t % 10);
    return {(t > 255) ? 1'b1 : 1'b0, h, te, u};
  endfunction

  task automatic sweep_check(input int a, input int b, input int cin);
    logic [12:0] e;
    e = model(a, b, cin);
    apply_check($sformatf("sweep a=%0d b=%0d cin=%0d", a, b, cin), 8'(a), 8'(b), cin[0],
                e[11:0], e[12]);
  endtask

  initial begin
    int bvals[7];
    checks   = 0;
    failures = 0;

    vecs[0]  = '{8'd110, 8'd10,  1'b0, 12'h120, 1'b0};
    vecs[1]  = '{8'd66,  8'd45,  1'b0, 12'h111, 1'b0};
    vecs[2]  = '{8'd30,  8'd36,  1'b1, 12'h067, 1'b0};
    vecs[3]  = '{8'd94,  8'd55,  1'b0, 12'h149, 1'b0};
    vecs[4]  = '{8'd0,   8'd0,   1'b0, 12'h000, 1'b0};
    vecs[5]  = '{8'd255, 8'd255, 1'b1, 12'h511, 1'b1};
    vecs[6]  = '{8'd200, 8'd55,  1'b0, 12'h255, 1'b0};
    vecs[7]  = '{8'd200, 8'd55,  1'b1, 12'h256, 1'b1};
    vecs[8]  = '{8'd99,  8'd0,   1'b0, 12'h099, 1'b0};
    vecs[9]  = '{8'd0,   8'd9,   1'b0, 12'h009, 1'b0};
    vecs[10] = '{8'd128, 8'd128, 1'b0, 12'h256, 1'b1};
    vecs[11] = '{8'd250, 8'd249, 1'b0, 12'h499, 1'b1};
    vecs[12] = '{8'd0,   8'd0,   1'b1, 12'h001, 1'b0};
    vecs[13] = '{8'd255, 8'd0,   1'b0, 12'h255, 1'b0};
    vecs[14] = '{8'd150, 8'd150, 1'b1, 12'h301, 1'b1};

    bvals = '{0, 1, 99, 100, 155, 156, 255};

    rst_n = 1'b1;
    A = 8'd0;
    B = 8'd0;
    C_in = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("reset_async", 12'h000, 1'b0);

    // Reset must hold the outputs at zero across clock edges
    A = 8'd255; B = 8'd255; C_in = 1'b1;
    @(posedge clk);
    #1 check("reset_hold", 12'h000, 1'b0);

    // First edge after release loads the inputs present at that edge
    @(negedge clk);
    rst_n = 1'b1;
    A = 8'd88; B = 8'd20; C_in = 1'b0;
    @(posedge clk);
    #1 check("first_after_reset", 12'h108, 1'b0);

    for (int i = 0; i < 15; i++)
      apply_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c);

    // Back-to-back sequence with no idle cycles
    apply_check("seq_108", 8'd88,  8'd20,  1'b0, 12'h108, 1'b0);
    apply_check("seq_100", 8'd91,  8'd9,   1'b0, 12'h100, 1'b0);
    apply_check("seq_511", 8'd255, 8'd255, 1'b1, 12'h511, 1'b1);

    // Mid-cycle reset clears outputs immediately and discards the pending sum
    apply(8'd110, 8'd10, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_cycle", 12'h000, 1'b0);
    @(posedge clk);
    #1 check("reset_discard", 12'h000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    A = 8'd94; B = 8'd55; C_in = 1'b0;
    @(posedge clk);
    #1 check("reset_recover", 12'h149, 1'b0);

    // No accumulation: same input twice gives the same result
    apply_check("repeat_1", 8'd66, 8'd45, 1'b0, 12'h111, 1'b0);
    apply_check("repeat_2", 8'd66, 8'd45, 1'b0, 12'h111, 1'b0);

    for (int a = 0; a < 256; a++)
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 7; k++)
          sweep_check(a, bvals[k], c);

    for (int b = 0; b < 256; b++)
      for (int c = 0; c < 2; c++) begin
        sweep_check(0, b, c);
        sweep_check(255, b, c);
        sweep_check(b ^ 8'h5a, b, c);
      end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
